// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - operand/result handshake bundle for bit_serial_adder
// SERIAL_ADDER_SUB_EN adds the SUB operand-mode signal.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             SUB;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             busy;

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  SUB,
`endif
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, busy
    );

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output SUB,
`endif
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, busy
    );
endinterface

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder, one full-adder cell, WIDTH cycles per op
// SERIAL_ADDER_SUB_EN enables subtract mode (A - B - Cin) via bus.SUB.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sub_mode;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] s_shifted;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_mode = bus.SUB;
`else
    assign sub_mode = 1'b0;
`endif

    // Subtraction is A + ~B + ~Cin, so only the loaded operand and seed carry differ.
    assign b_load = bus.B ^ {WIDTH{sub_mode}};
    assign c_load = bus.Cin ^ sub_mode;

    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign s_shifted = (s_sh_q >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = carry_bit;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_shifted;
                cnt_d   = cnt_q + CW'(1);
                // Last bit: publish the completed sum on the same edge.
                if (cnt_q == CW'(WIDTH-1)) begin
                    s_d     = s_shifted;
                    cout_d  = carry_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder
module tb_bit_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub)
            r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin} + {1'b1, {W{1'b0}}};
        else
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    task automatic set_sub(input logic sub);
`ifdef SERIAL_ADDER_SUB_EN
        bus.SUB = sub;
`else
        if (sub) $display("note: subtract requested in add-only build");
`endif
    endtask

    // One complete operation: accept, wait for result, hold backpressure, handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int hold, input bit scramble,
                         input logic [W-1:0] es, input logic ecout, input string tag);
        int lat;
        int waited;
        waited = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        while (!bus.in_ready && waited < 4 * W) begin
            tick();
            waited++;
        end
        check({tag, "_in_ready_before_accept"}, bus.in_ready, 1'b1);
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        set_sub(sub);
        bus.in_valid = 1'b1;
        tick();
        if (!scramble) bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < W + 4) begin
            if (scramble) begin
                bus.A   = W'($urandom);
                bus.B   = W'($urandom);
                bus.Cin = 1'($urandom);
                set_sub(1'($urandom) & sub);
            end
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_result"}, {bus.Cout, bus.S}, {ecout, es});
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                bus.A = W'($urandom);
                bus.B = W'($urandom);
            end
            tick();
            check({tag, "_hold_{valid,in_ready,Cout,S}"},
                  {bus.out_valid, bus.in_ready, bus.Cout, bus.S},
                  {1'b1, 1'b0, ecout, es});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_after_hs_{in_ready,out_valid,busy}"},
              {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        check({tag, "_retained"}, {bus.Cout, bus.S}, {ecout, es});
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W:0] exp;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        bit   saw_valid;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A   = '0;
        bus.B   = '0;
        bus.Cin = 1'b0;
        set_sub(1'b0);

        tbl.push_back('{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
        tbl.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        tbl.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1});
        tbl.push_back('{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0});
        tbl.push_back('{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif

        repeat (2) tick();
        rst = 1'b0;
        check("reset_{in_ready,out_valid,busy,Cout,S}",
              {bus.in_ready, bus.out_valid, bus.busy, bus.Cout, bus.S},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        foreach (tbl[i])
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, (i == 1) ? 5 : 0, 1'b0,
                  tbl[i].s, tbl[i].cout, $sformatf("vec%0d", i));

        // Backpressure: five cycles with out_ready low in DONE.
        do_op(8'h05, 8'h03, 1'b0, 1'b0, 5, 1'b0, 8'h08, 1'b0, "backpressure");

        // Reset sampled on the third RUN edge aborts the operation.
        bus.A = 8'h7F; bus.B = 8'h01; bus.Cin = 1'b0; set_sub(1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_{in_ready,out_valid,busy,Cout,S}",
              {bus.in_ready, bus.out_valid, bus.busy, bus.Cout, bus.S},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        saw_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (W + 4) begin
            tick();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        bus.out_ready = 1'b0;
        check("abort_no_result", saw_valid, 1'b0);

        // in_valid held through RUN/DONE with churning operands.
        do_op(8'h3C, 8'h0F, 1'b1, 1'b0, 3, 1'b1, 8'h4C, 1'b0, "scramble");

        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            exp = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  exp[W-1:0], exp[W], $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
